mux_n_pipe_sel: RTL and testbench

//   Parametrised N-way, WIDTH-bit operand/result select mux with a registered output stage.

---
 rtl/mux_n_pipe_sel.sv | 173 +++++++++++++++++
 tb/tb_mux_n_pipe_sel.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe_sel.sv
// mux_n_pipe_sel: N-way WIDTH-bit select mux with a registered output stage.
// The selected beat {data, sel, err} is captured at accept into a two-entry
// (main + skid) buffer. Because in_ready is a flop, the select path is retimed
// without any combinational ready loop from out_ready back to in_ready.
module mux_n_pipe_sel #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        err_cnt
);

    // Every encodable select value gets a slot; unused slots read as zero
    // and are flagged as out-of-range, so indexing never leaves the array.
    localparam int NUM_SLOTS = 1 << SEL_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               in_ready_reg;

    logic [WIDTH-1:0]   m_data_reg, s_data_reg;
    logic [SEL_W-1:0]   m_sel_reg,  s_sel_reg;
    logic               m_err_reg,  s_err_reg;
    logic [CNT_W-1:0]   err_cnt_reg;

    logic [WIDTH-1:0]   slot_data [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_ok;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_err;

    logic               accept;
    logic               take;
    logic               load_m;
    logic               load_s;
    logic               move_s;

    // Unflatten the input bus into a select table padded to 2**SEL_W entries.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi < NUM_IN) begin : g_live
                assign slot_data[gi] = in_data[gi*WIDTH +: WIDTH];
                assign slot_ok[gi]   = 1'b1;
            end else begin : g_pad
                assign slot_data[gi] = '0;
                assign slot_ok[gi]   = 1'b0;
            end
        end
    endgenerate

    // Pad slots already hold zero, so an out-of-range select yields data 0.
    assign sel_data = slot_data[in_sel];
    assign sel_err  = ~slot_ok[in_sel];

    // A beat offered during flush is dropped outright.
    assign accept = in_valid & in_ready_reg & ~flush;
    assign take   = (state_reg != ST_EMPTY) & out_ready;

    // Occupancy FSM: decide next state and which buffer register moves.
    always_comb begin
        state_next = state_reg;
        load_m     = 1'b0;
        load_s     = 1'b0;
        move_s     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        load_m     = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        load_m = 1'b1;
                    end else if (accept) begin
                        load_s     = 1'b1;
                        state_next = ST_TWO;
                    end else if (take) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so no accept can coincide.
                    if (take) begin
                        move_s     = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered from the next state so it drops
    // in the same cycle the buffer becomes full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_TWO);
        end
    end

    // Main register: loads a fresh beat or the skid entry when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_reg <= '0;
            m_sel_reg  <= '0;
            m_err_reg  <= 1'b0;
        end else if (load_m) begin
            m_data_reg <= sel_data;
            m_sel_reg  <= in_sel;
            m_err_reg  <= sel_err;
        end else if (move_s) begin
            m_data_reg <= s_data_reg;
            m_sel_reg  <= s_sel_reg;
            m_err_reg  <= s_err_reg;
        end
    end

    // Skid register: holds the overflow beat while the main entry is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data_reg <= '0;
            s_sel_reg  <= '0;
            s_err_reg  <= 1'b0;
        end else if (load_s) begin
            s_data_reg <= sel_data;
            s_sel_reg  <= in_sel;
            s_err_reg  <= sel_err;
        end
    end

    // Saturating count of accepted out-of-range beats; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (accept && sel_err && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != ST_EMPTY);
    assign out_data  = m_data_reg;
    assign out_sel   = m_sel_reg;
    assign out_err   = m_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_mux_n_pipe_sel.sv
// Testbench for mux_n_pipe_sel: a queue of expected beats is filled when a beat
// is accepted and drained/compared whenever the DUT presents a beat.
module tb_mux_n_pipe_sel;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        err_cnt;

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t            sb_q[$];
    logic             in_ready_m;
    int               err_cnt_m;
    int               checks;
    int               failures;
    int               accepted;
    int               delivered;
    logic [WIDTH-1:0] ch [NUM_IN];

    always #5 clk = ~clk;

    mux_n_pipe_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: at the falling edge compare outputs with the model,
    // then drive the next inputs and advance the model to the next edge.
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic ordy, input logic fl);
        beat_t e;
        logic  acc;
        logic  tk;
        int    idx;
        @(negedge clk);
        check_val("in_ready", 64'(in_ready), 64'(in_ready_m));
        check_val("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        check_val("err_cnt", 64'(err_cnt), 64'(err_cnt_m));
        if (sb_q.size() > 0)
            check_val("beat", 64'({out_err, out_sel, out_data}), 64'(sb_q[0]));
        for (int k = 0; k < NUM_IN; k++)
            in_data[k*WIDTH +: WIDTH] = ch[k];
        in_valid  = v;
        in_sel    = s;
        out_ready = ordy;
        flush     = fl;
        acc = v && in_ready_m && !fl;
        tk  = (sb_q.size() > 0) && ordy;
        if (tk) begin
            e = sb_q.pop_front();
            delivered++;
            $display("beat out #%0d data=%h sel=%0d err=%0d", delivered, e.data, e.sel, e.err);
        end
        if (fl) begin
            sb_q.delete();
        end else if (acc) begin
            idx   = int'(s);
            e.sel = s;
            e.err = (idx >= NUM_IN);
            e.data = (idx < NUM_IN) ? ch[idx] : '0;
            sb_q.push_back(e);
            accepted++;
            if (e.err && err_cnt_m < CNT_MAX)
                err_cnt_m++;
        end
        in_ready_m = (sb_q.size() != 2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        checks = 0; failures = 0; accepted = 0; delivered = 0;
        err_cnt_m = 0; in_ready_m = 1'b0;
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < NUM_IN; k++) ch[k] = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'(0));
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_data", 64'(out_data), 64'(0));
        check_val("rst_out_sel", 64'(out_sel), 64'(0));
        check_val("rst_out_err", 64'(out_err), 64'(0));
        check_val("rst_err_cnt", 64'(err_cnt), 64'(0));
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready", 64'(in_ready), 64'(0));
        in_ready_m = 1'b1;

        // 1: back-to-back stream, one-cycle latency, no bubbles
        for (int k = 0; k < NUM_IN; k++) ch[k] = 32'h1000_0000 + k;
        for (int k = 0; k < 4; k++) step(1'b1, SEL_W'(k), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // 2: out-of-range select gives data 0, err 1, counter 1
        for (int k = 0; k < NUM_IN; k++) ch[k] = 32'hAAAA_AAAA;
        step(1'b1, 3'd5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        // an error beat offered in a flush cycle is neither accepted nor counted
        step(1'b1, 3'd4, 1'b0, 1'b0);
        step(1'b1, 3'd6, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        // saturation after 300 error beats
        for (int i = 0; i < 300; i++) step(1'b1, SEL_W'(5 + (i % 3)), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // 3: fill both entries with A=11, B=22 while stalled, then drain in order
        ch[0] = 32'd11; ch[1] = 32'd22; ch[2] = 32'd44;
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 4: flush in TWO with a simultaneous offer and transfer
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        ch[2] = 32'd33;
        step(1'b1, 3'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 5: asynchronous reset mid-cycle while holding one beat
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'(0));
        check_val("arst_in_ready", 64'(in_ready), 64'(0));
        check_val("arst_err_cnt", 64'(err_cnt), 64'(0));
        sb_q.delete();
        err_cnt_m = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("arel_in_ready", 64'(in_ready), 64'(0));
        in_ready_m = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("arel_out_data", 64'(out_data), 64'(0));

        // 6: random traffic against the scoreboard
        cyc = 0;
        accepted = 0;
        while (accepted < 10000 && cyc < 60000) begin
            for (int k = 0; k < NUM_IN; k++) ch[k] = $urandom;
            step(($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
            cyc++;
        end
        check_val("accept_budget", 64'(accepted >= 10000), 64'(1));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
